// File: rtl/rv_core_pkg.sv
// Shared definitions for the pipelined RISC-V core: datapath widths and
// register-file sequencer states used across pipeline-stage blocks.
package rv_core_pkg;

   localparam int XLEN    = 32;
   localparam int REG_NUM = 32;
   localparam int REG_AW  = 5;

   typedef enum logic {
      ST_CLEAR,
      ST_RUN
   } rf_state_e;

endpackage

// File: rtl/rf_bypass_read.sv
// One register-file read port: x0 hardwiring, same-cycle WB bypass and array
// data selection, with a force-to-zero used while the file is being cleared.
module rf_bypass_read
   import rv_core_pkg::*;
(
   input  logic [REG_AW-1:0] rr,
   input  logic              force_zero,
   input  logic              wr_en,
   input  logic [REG_AW-1:0] wr_idx,
   input  logic [XLEN-1:0]   wr_data,
   input  logic [XLEN-1:0]   arr_data,
   output logic [XLEN-1:0]   rd
);

   // The bypass only ever sees qualified writes, so a write to x0 cannot leak here.
   always_comb begin
      rd = '0;
      if (!force_zero && (rr != '0)) begin
         if (wr_en && (wr_idx == rr)) begin
            rd = wr_data;
         end else begin
            rd = arr_data;
         end
      end
   end

endmodule

// File: rtl/wb_regfile_commit.sv
// 32x32 integer register file fed by MEM/WB, with a post-reset clear sequencer,
// two bypassed read ports, a registered commit trace and a retired-instruction counter.
module wb_regfile_commit
   import rv_core_pkg::*;
#(
   parameter int CNT_W          = 32,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] wb_wR,
   input  logic [XLEN-1:0]   wb_wD,
   input  logic [XLEN-1:0]   wb_pc,
   input  logic              wb_have_inst,
   input  logic              wb_rf_we,
   input  logic [REG_AW-1:0] rR1,
   input  logic [REG_AW-1:0] rR2,
   output logic [XLEN-1:0]   rD1,
   output logic [XLEN-1:0]   rD2,
   output logic              rf_ready,
   output logic              commit_valid,
   output logic [XLEN-1:0]   commit_pc,
   output logic [REG_AW-1:0] commit_rd,
   output logic              commit_we,
   output logic [XLEN-1:0]   commit_data,
   output logic [CNT_W-1:0]  instret,
   output logic              wr_drop
);

   localparam rf_state_e RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
   localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(REG_NUM - 1);

   logic [XLEN-1:0]   regs [REG_NUM];
   rf_state_e         state;
   rf_state_e         state_next;
   logic [REG_AW-1:0] clr_idx;
   logic              in_clear;
   logic              wr_en;

   assign in_clear = (state == ST_CLEAR);
   assign wr_en    = !in_clear && wb_rf_we && wb_have_inst && (wb_wR != '0);
   assign rf_ready = (state == ST_RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RESET_STATE;
         clr_idx <= REG_AW'(1);
      end else begin
         state <= state_next;
         if (in_clear) begin
            clr_idx <= clr_idx + REG_AW'(1);
         end
      end
   end

   always_comb begin
      state_next = state;
      if (in_clear && (clr_idx == LAST_IDX)) begin
         state_next = ST_RUN;
      end
   end

   // Storage is deliberately left out of reset; the clear sequence initialises it.
   always_ff @(posedge clk) begin
      if (in_clear) begin
         regs[clr_idx] <= '0;
      end else if (wr_en) begin
         regs[wb_wR] <= wb_wD;
      end
   end

   rf_bypass_read u_read1 (
      .rr         (rR1),
      .force_zero (in_clear),
      .wr_en      (wr_en),
      .wr_idx     (wb_wR),
      .wr_data    (wb_wD),
      .arr_data   (regs[rR1]),
      .rd         (rD1)
   );

   rf_bypass_read u_read2 (
      .rr         (rR2),
      .force_zero (in_clear),
      .wr_en      (wr_en),
      .wr_idx     (wb_wR),
      .wr_data    (wb_wD),
      .arr_data   (regs[rR2]),
      .rd         (rD2)
   );

   // Trace fields hold between retirements so debug logic can read them at leisure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         commit_valid <= 1'b0;
         commit_pc    <= '0;
         commit_rd    <= '0;
         commit_we    <= 1'b0;
         commit_data  <= '0;
         instret      <= '0;
         wr_drop      <= 1'b0;
      end else begin
         commit_valid <= 1'b0;
         if (in_clear) begin
            if (wb_have_inst || wb_rf_we) begin
               wr_drop <= 1'b1;
            end
         end else if (wb_have_inst) begin
            commit_valid <= 1'b1;
            commit_pc    <= wb_pc;
            commit_rd    <= wb_wR;
            commit_we    <= wr_en;
            commit_data  <= wr_en ? wb_wD : '0;
            instret      <= instret + CNT_W'(1);
         end
      end
   end

endmodule
